// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// fetch FSM states and the undefined-instruction filler word.
package instr_fetch_unit_pkg;

  localparam logic [1:0] PC_S_INC  = 2'b00;
  localparam logic [1:0] PC_S_BR   = 2'b01;
  localparam logic [1:0] PC_S_ALU  = 2'b10;
  localparam logic [1:0] PC_S_HOLD = 2'b11;

  localparam logic [31:0] INSN_UNDEF = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: sequential, branch offset, register
// indirect or hold. All sums wrap modulo 2^32.
module pc_next_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_s,
  input  logic [23:0] imm24,
  input  logic [31:0] alu_f,
  output logic [31:0] pc_next
);

  logic [31:0] br_offset;

  // imm24 counts words, so it is sign-extended and scaled to bytes
  assign br_offset = {{6{imm24[23]}}, imm24, 2'b00};

  always_comb begin
    pc_next = pc;
    unique case (pc_s)
      PC_S_INC:  pc_next = pc + 32'd4;
      PC_S_BR:   pc_next = pc + br_offset;
      PC_S_ALU:  pc_next = alu_f & 32'hFFFF_FFFC;
      PC_S_HOLD: pc_next = pc;
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC/IR owner fetching instruction words over a variable-latency req/ack
// memory port. Define IF_TIMEOUT_EN to add the fetch timeout watchdog.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_pc,
  input  logic        write_ir,
  input  logic [1:0]  pc_s,
  input  logic [23:0] imm24,
  input  logic [31:0] alu_f,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] I,
  output logic        W_IR_valid,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  ir_q, ir_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_next;

  pc_next_calc u_pc_next_calc (
    .pc      (pc_q),
    .pc_s    (pc_s),
    .imm24   (imm24),
    .alu_f   (alu_f),
    .pc_next (pc_next)
  );

`ifdef IF_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      fetch_addr_q <= 32'd0;
      ir_q         <= 32'd0;
      valid_q      <= 1'b0;
`ifdef IF_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      ir_q         <= ir_d;
      valid_q      <= valid_d;
`ifdef IF_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // The fetch address is captured from pc_q, so a same-edge PC update never
  // affects the word being fetched.
  always_comb begin
    state_d      = state_q;
    pc_d         = write_pc ? pc_next : pc_q;
    fetch_addr_d = fetch_addr_q;
    ir_d         = ir_q;
    valid_d      = 1'b0;
`ifdef IF_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (write_ir) begin
          fetch_addr_d = pc_q;
          state_d      = ST_REQ;
`ifdef IF_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_IDLE;
`ifdef IF_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          ir_d    = INSN_UNDEF;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req   = (state_q == ST_REQ);
  assign busy       = (state_q == ST_REQ);
  assign imem_addr  = fetch_addr_q;
  assign I          = ir_q;
  assign W_IR_valid = valid_q;
  assign pc         = pc_q;
`ifdef IF_TIMEOUT_EN
  assign fetch_err  = err_q;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule
